sync_start_gen: RTL and testbench

Master start sequencer placed directly upstream of `cntr_module`. On a start command it pulses the counter reset, then emits a periodic triple of one-cycle sync strobes (`sync0`, `sync1`, `sync2`) at programmable offsets within each period. It runs for a programmed number of periods, or continuously until stopped. Its outputs connect one-to-one to `cntr_module`'s `rst`, `sync0`, `sync1` and `sync2` inputs.

---
 rtl/sync_start_gen.sv | 177 +++++++++++++++++
 tb/tb_sync_start_gen.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sync_start_gen.sv
// Start sequencer for cntr_module: pulses the counter reset, then emits a
// periodic sync0/sync1/sync2 strobe triple for a burst or until stopped.
module sync_start_gen #(
  parameter int CNT_W   = 16,
  parameter int RST_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] delay1,
  input  logic [CNT_W-1:0] delay2,
  input  logic [CNT_W-1:0] n_periods,
  output logic             cntr_rst,
  output logic             sync0,
  output logic             sync1,
  output logic             sync2,
  output logic             busy,
  output logic             done
);

  localparam int              RC_W  = (RST_LEN > 1) ? $clog2(RST_LEN) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_LEN - 1);
  localparam logic [RC_W-1:0] RC_ONE  = RC_W'(1);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_TWO  = CNT_W'(2);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN} state_t;

  state_t           r_state, w_state_next;
  logic [RC_W-1:0]  r_rst_cnt, w_rst_cnt_next;
  logic [CNT_W-1:0] r_ph, w_ph_next;
  logic [CNT_W-1:0] r_np, w_np_next;
  logic [CNT_W-1:0] r_last, w_last_next;
  logic [CNT_W-1:0] r_delay1, w_delay1_next;
  logic [CNT_W-1:0] r_delay2, w_delay2_next;
  logic [CNT_W-1:0] r_n_periods, w_n_periods_next;
  logic             r_stop_pending, w_stop_pending_next;
  logic             r_cntr_rst, w_cntr_rst_next;
  logic             r_sync0, w_sync0_next;
  logic             r_sync1, w_sync1_next;
  logic             r_sync2, w_sync2_next;
  logic             r_busy, w_busy_next;
  logic             r_done, w_done_next;

  logic [CNT_W-1:0] w_ph_inc;
  logic [CNT_W-1:0] w_np_inc;
  logic             w_burst_end;

  assign w_ph_inc    = r_ph + C_ONE;
  assign w_np_inc    = r_np + C_ONE;
  assign w_burst_end = (r_n_periods != '0) && (w_np_inc == r_n_periods);

  // Outputs are registered from the next-state decode so they line up with the state.
  always_comb begin
    w_state_next        = r_state;
    w_rst_cnt_next      = r_rst_cnt;
    w_ph_next           = r_ph;
    w_np_next           = r_np;
    w_last_next         = r_last;
    w_delay1_next       = r_delay1;
    w_delay2_next       = r_delay2;
    w_n_periods_next    = r_n_periods;
    w_stop_pending_next = r_stop_pending;
    w_cntr_rst_next     = 1'b0;
    w_sync0_next        = 1'b0;
    w_sync1_next        = 1'b0;
    w_sync2_next        = 1'b0;
    w_busy_next         = 1'b0;
    w_done_next         = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next        = S_ARM;
          w_rst_cnt_next      = '0;
          // Store P-1 with periods below 2 clamped to 2.
          w_last_next         = (period < C_TWO) ? C_ONE : (period - C_ONE);
          w_delay1_next       = delay1;
          w_delay2_next       = delay2;
          w_n_periods_next    = n_periods;
          w_stop_pending_next = 1'b0;
          w_cntr_rst_next     = 1'b1;
          w_busy_next         = 1'b1;
        end
      end

      S_ARM: begin
        w_stop_pending_next = r_stop_pending | stop;
        w_busy_next         = 1'b1;
        if (r_rst_cnt == RC_LAST) begin
          w_state_next = S_RUN;
          w_ph_next    = '0;
          w_np_next    = '0;
          w_sync0_next = 1'b1;
          w_sync1_next = (r_delay1 == '0);
          w_sync2_next = (r_delay2 == '0);
        end else begin
          w_rst_cnt_next  = r_rst_cnt + RC_ONE;
          w_cntr_rst_next = 1'b1;
        end
      end

      S_RUN: begin
        w_stop_pending_next = r_stop_pending | stop;
        if (r_ph == r_last) begin
          if (w_burst_end || r_stop_pending || stop) begin
            w_state_next        = S_IDLE;
            w_stop_pending_next = 1'b0;
            w_done_next         = 1'b1;
          end else begin
            w_ph_next    = '0;
            w_np_next    = (r_np == '1) ? r_np : w_np_inc;
            w_busy_next  = 1'b1;
            w_sync0_next = 1'b1;
            w_sync1_next = (r_delay1 == '0);
            w_sync2_next = (r_delay2 == '0);
          end
        end else begin
          w_ph_next    = w_ph_inc;
          w_busy_next  = 1'b1;
          w_sync1_next = (r_delay1 == w_ph_inc);
          w_sync2_next = (r_delay2 == w_ph_inc);
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_rst_cnt      <= '0;
      r_ph           <= '0;
      r_np           <= '0;
      r_last         <= '0;
      r_delay1       <= '0;
      r_delay2       <= '0;
      r_n_periods    <= '0;
      r_stop_pending <= 1'b0;
      r_cntr_rst     <= 1'b0;
      r_sync0        <= 1'b0;
      r_sync1        <= 1'b0;
      r_sync2        <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_rst_cnt      <= w_rst_cnt_next;
      r_ph           <= w_ph_next;
      r_np           <= w_np_next;
      r_last         <= w_last_next;
      r_delay1       <= w_delay1_next;
      r_delay2       <= w_delay2_next;
      r_n_periods    <= w_n_periods_next;
      r_stop_pending <= w_stop_pending_next;
      r_cntr_rst     <= w_cntr_rst_next;
      r_sync0        <= w_sync0_next;
      r_sync1        <= w_sync1_next;
      r_sync2        <= w_sync2_next;
      r_busy         <= w_busy_next;
      r_done         <= w_done_next;
    end
  end

  assign cntr_rst = r_cntr_rst;
  assign sync0    = r_sync0;
  assign sync1    = r_sync1;
  assign sync2    = r_sync2;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_sync_start_gen.sv
// Directed bench for sync_start_gen: each scenario drives inputs per cycle and
// compares every output against hand-written cycle lists.
module tb_sync_start_gen;

  localparam int CNT_W   = 16;
  localparam int RST_LEN = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             stop;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] delay1;
  logic [CNT_W-1:0] delay2;
  logic [CNT_W-1:0] n_periods;
  logic             cntr_rst;
  logic             sync0;
  logic             sync1;
  logic             sync2;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  sync_start_gen #(
    .CNT_W   (CNT_W),
    .RST_LEN (RST_LEN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .period    (period),
    .delay1    (delay1),
    .delay2    (delay2),
    .n_periods (n_periods),
    .cntr_rst  (cntr_rst),
    .sync0     (sync0),
    .sync1     (sync1),
    .sync2     (sync2),
    .busy      (busy),
    .done      (done)
  );

  // Inputs set in cycle c are sampled at the edge ending c; outputs are read
  // 1 ns after that edge and labelled cycle c+1.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc = cyc + 1;
  endtask

  task automatic chk(input string tag, input logic got, input logic exp);
    checks = checks + 1;
    assert (got === exp) else begin
      errors = errors + 1;
      $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, got, exp);
    end
  endtask

  // e = {cntr_rst, sync0, sync1, sync2, busy, done}
  task automatic chk_all(input string name, input logic [5:0] e);
    chk({name, ".cntr_rst"}, cntr_rst, e[5]);
    chk({name, ".sync0"},    sync0,    e[4]);
    chk({name, ".sync1"},    sync1,    e[3]);
    chk({name, ".sync2"},    sync2,    e[2]);
    chk({name, ".busy"},     busy,     e[1]);
    chk({name, ".done"},     done,     e[0]);
  endtask

  function automatic logic rng(input int c, input int lo, input int hi);
    return (c >= lo) && (c <= hi);
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    period = 16'd0; delay1 = 16'd0; delay2 = 16'd0; n_periods = 16'd0;
    tick();
    tick();
    chk_all("reset", 6'b000000);
    rst = 1'b0;

    // Burst of 3; config changed after start must not matter
    cyc = 0;
    repeat (45) begin
      start = (cyc == 10);
      period = (cyc <= 10) ? 16'd8 : 16'd3;
      delay1 = (cyc <= 10) ? 16'd2 : 16'd7;
      delay2 = 16'd5; n_periods = 16'd3;
      tick();
      chk_all("burst", {rng(cyc, 11, 14), (cyc == 15 || cyc == 23 || cyc == 31),
                        (cyc == 17 || cyc == 25 || cyc == 33), (cyc == 20 || cyc == 28 || cyc == 36),
                        rng(cyc, 11, 38), (cyc == 39)});
    end

    // Continuous with stop at cycle 27
    cyc = 0;
    repeat (40) begin
      start = (cyc == 10); stop = (cyc == 27);
      period = 16'd6; delay1 = 16'd1; delay2 = 16'd3; n_periods = 16'd0;
      tick();
      chk_all("cont_stop", {rng(cyc, 11, 14), (cyc == 15 || cyc == 21 || cyc == 27),
                            (cyc == 16 || cyc == 22 || cyc == 28), (cyc == 18 || cyc == 24 || cyc == 30),
                            rng(cyc, 11, 32), (cyc == 33)});
    end
    stop = 1'b0;

    // Period 1 clamps to 2; delay1=0 coincides with sync0
    cyc = 0;
    repeat (25) begin
      start = (cyc == 10);
      period = 16'd1; delay1 = 16'd0; delay2 = 16'd1; n_periods = 16'd3;
      tick();
      chk_all("clamp", {rng(cyc, 11, 14), (cyc == 15 || cyc == 17 || cyc == 19),
                        (cyc == 15 || cyc == 17 || cyc == 19), (cyc == 16 || cyc == 18 || cyc == 20),
                        rng(cyc, 11, 20), (cyc == 21)});
    end

    // delay2 equal to period never fires
    cyc = 0;
    repeat (35) begin
      start = (cyc == 10);
      period = 16'd8; delay1 = 16'd0; delay2 = 16'd8; n_periods = 16'd2;
      tick();
      chk_all("delay_ge_p", {rng(cyc, 11, 14), (cyc == 15 || cyc == 23),
                             (cyc == 15 || cyc == 23), 1'b0, rng(cyc, 11, 30), (cyc == 31)});
    end

    // Reset at second-period phase 3, then a full replay
    cyc = 0;
    repeat (62) begin
      rst = (cyc == 26); start = (cyc == 10 || cyc == 30);
      period = 16'd8; delay1 = 16'd2; delay2 = 16'd5; n_periods = 16'd3;
      tick();
      chk_all("mid_reset", {(rng(cyc, 11, 14) || rng(cyc, 31, 34)),
                            (cyc == 15 || cyc == 23 || cyc == 35 || cyc == 43 || cyc == 51),
                            (cyc == 17 || cyc == 25 || cyc == 37 || cyc == 45 || cyc == 53),
                            (cyc == 20 || cyc == 40 || cyc == 48 || cyc == 56),
                            (rng(cyc, 11, 26) || rng(cyc, 31, 58)), (cyc == 59)});
    end
    rst = 1'b0;

    // start+stop together in IDLE, then start pulses during RUN
    cyc = 0;
    repeat (30) begin
      start = (cyc == 10 || cyc == 17 || cyc == 21); stop = (cyc == 10);
      period = 16'd5; delay1 = 16'd1; delay2 = 16'd2; n_periods = 16'd2;
      tick();
      chk_all("start_stop_idle", {rng(cyc, 11, 14), (cyc == 15 || cyc == 20),
                                  (cyc == 16 || cyc == 21), (cyc == 17 || cyc == 22),
                                  rng(cyc, 11, 24), (cyc == 25)});
    end
    start = 1'b0; stop = 1'b0;

    // stop during ARM gives exactly one period
    cyc = 0;
    repeat (25) begin
      start = (cyc == 10); stop = (cyc == 12);
      period = 16'd5; delay1 = 16'd1; delay2 = 16'd2; n_periods = 16'd0;
      tick();
      chk_all("stop_in_arm", {rng(cyc, 11, 14), (cyc == 15), (cyc == 16), (cyc == 17),
                              rng(cyc, 11, 19), (cyc == 20)});
    end
    stop = 1'b0;

    // start held high: re-accepted in the done cycle
    cyc = 0;
    repeat (30) begin
      start = (cyc >= 10);
      period = 16'd4; delay1 = 16'd1; delay2 = 16'd2; n_periods = 16'd1;
      tick();
      chk_all("back_to_back", {(rng(cyc, 11, 14) || rng(cyc, 20, 23) || rng(cyc, 29, 30)),
                               (cyc == 15 || cyc == 24), (cyc == 16 || cyc == 25),
                               (cyc == 17 || cyc == 26),
                               (rng(cyc, 11, 18) || rng(cyc, 20, 27) || rng(cyc, 29, 30)),
                               (cyc == 19 || cyc == 28)});
    end

    start = 1'b0; rst = 1'b1;
    tick();
    chk_all("final_reset", 6'b000000);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
